// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the WM8731 configuration scheduler: FSM state
// encodings, codec register addresses and the power-up init table.
package codec_cfg_pkg;

   // State encodings; the numeric values are exported on state_info for LEDs.
   typedef enum logic [3:0] {
      S_BOOT     = 4'd0,
      S_LOAD     = 4'd1,
      S_IDLE     = 4'd2,
      S_BYTE0    = 4'd3,
      S_BYTE1    = 4'd4,
      S_WAIT_RDY = 4'd5,
      S_GAP      = 4'd6
   } state_e;

   // WM8731 register addresses.
   localparam logic [6:0] WM_R4_ANALOG   = 7'h04;
   localparam logic [6:0] WM_R6_POWER    = 7'h06;
   localparam logic [6:0] WM_R7_IFACE    = 7'h07;
   localparam logic [6:0] WM_R8_SAMPLING = 7'h08;
   localparam logic [6:0] WM_R9_ACTIVE   = 7'h09;
   localparam logic [6:0] WM_R15_RESET   = 7'h0F;

   // One codec register write: 7-bit address plus 9-bit value.
   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } reg_wr_t;

   // Power-up sequence: reset, power everything on, route DAC to output,
   // I2S 16-bit slave, normal-mode 48k sampling, then activate the interface.
   // Indices past the table repeat the harmless "active" write.
   function automatic reg_wr_t init_entry(input logic [3:0] idx);
      reg_wr_t w;
      case (idx)
         4'd0:    w = '{addr: WM_R15_RESET,   data: 9'h000};
         4'd1:    w = '{addr: WM_R6_POWER,    data: 9'h000};
         4'd2:    w = '{addr: WM_R4_ANALOG,   data: 9'h012};
         4'd3:    w = '{addr: WM_R7_IFACE,    data: 9'h002};
         4'd4:    w = '{addr: WM_R8_SAMPLING, data: 9'h000};
         default: w = '{addr: WM_R9_ACTIVE,   data: 9'h001};
      endcase
      return w;
   endfunction

   // First I2C data byte: register address followed by the value MSB.
   function automatic logic [7:0] payload_byte0(input reg_wr_t w);
      return {w.addr, w.data[8]};
   endfunction

   // Second I2C data byte: low eight bits of the value.
   function automatic logic [7:0] payload_byte1(input reg_wr_t w);
      return w.data[7:0];
   endfunction

endpackage

// File: rtl/codec_cfg_timer.sv
// Loadable down-counter shared by the per-byte timeout and the
// inter-transaction gap. expire_o is high while the count sits at zero.
module codec_cfg_timer
   import codec_cfg_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload on request, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/codec_cfg_scheduler.sv
// Serialises every WM8731 register write through the shared I2C byte
// controller: replays the init table after reset, then serves runtime
// requests one at a time with a per-byte timeout and an idle gap.
module codec_cfg_scheduler
   import codec_cfg_pkg::*;
#(
   parameter logic [6:0]  PERIPH_ADDR    = 7'b0011010,
   parameter int          INIT_LEN       = 6,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000,
   parameter logic [15:0] GAP_CYCLES     = 16'd1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [6:0] req_reg,
   input  logic [8:0] req_data,
   output logic       req_ready,
   output logic       i2c_enable,
   output logic       i2c_mode,
   output logic [6:0] i2c_periph_addr,
   output logic [7:0] i2c_input_byte,
   input  logic       i2c_ready,
   input  logic       i2c_write_in_progress,
   output logic       init_done,
   output logic       busy,
   output logic       error,
   output logic [3:0] state_info
);

   localparam logic [3:0]  LAST_IDX = 4'(INIT_LEN - 1);
   // The timer expires on its last counted cycle, hence the minus one.
   localparam logic [19:0] TO_LOAD  = (TIMEOUT_CYCLES == 20'd0) ? 20'd0
                                      : TIMEOUT_CYCLES - 20'd1;
   localparam logic [19:0] GAP_LOAD = (GAP_CYCLES == 16'd0) ? 20'd0
                                      : {4'd0, GAP_CYCLES} - 20'd1;

   state_e      state_q, state_d;
   logic [3:0]  idx_q;
   logic        wip_q;
   logic        en_q;
   logic [7:0]  byte_q;
   logic        init_done_q;
   logic        err_q;
   reg_wr_t     wr_q, wr_d;

   logic        wip_rise;
   logic        err_set;
   logic        idx_inc;
   logic        init_fin;
   logic        tmr_load;
   logic [19:0] tmr_val;
   logic        tmr_expire;

   assign wip_rise = i2c_write_in_progress && !wip_q;

   // Any state change restarts the shared timer: gap length in S_GAP,
   // timeout budget everywhere else.
   assign tmr_load = (state_d != state_q);
   assign tmr_val  = (state_d == S_GAP) ? GAP_LOAD : TO_LOAD;

   codec_cfg_timer #(
      .CNT_W (20)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   // Next-state and side-effect decode; a wip rise outranks a timeout.
   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      err_set  = 1'b0;
      idx_inc  = 1'b0;
      init_fin = 1'b0;
      case (state_q)
         S_BOOT: begin
            if (i2c_ready) state_d = S_LOAD;
         end
         S_LOAD: begin
            wr_d    = init_entry(idx_q);
            state_d = S_BYTE0;
         end
         S_IDLE: begin
            if (req_valid) begin
               wr_d.addr = req_reg;
               wr_d.data = req_data;
               state_d   = S_BYTE0;
            end
         end
         S_BYTE0: begin
            if (wip_rise) begin
               state_d = S_BYTE1;
            end else if (tmr_expire) begin
               err_set = 1'b1;
               state_d = S_WAIT_RDY;
            end
         end
         S_BYTE1: begin
            if (wip_rise) begin
               state_d = S_WAIT_RDY;
            end else if (tmr_expire) begin
               err_set = 1'b1;
               state_d = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (i2c_ready) begin
               state_d = S_GAP;
            end else if (tmr_expire) begin
               // Controller never freed the bus: give up on this entry.
               err_set = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (tmr_expire) begin
               if (!init_done_q && (idx_q < LAST_IDX)) begin
                  idx_inc = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  init_fin = !init_done_q;
                  state_d  = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // FSM state, sticky flags and registered controller-facing outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_BOOT;
         idx_q       <= 4'd0;
         wip_q       <= 1'b0;
         en_q        <= 1'b0;
         byte_q      <= 8'h00;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         wip_q   <= i2c_write_in_progress;
         en_q    <= (state_d == S_BYTE0) || (state_d == S_BYTE1);
         case (state_d)
            S_BYTE0: byte_q <= payload_byte0(wr_d);
            S_BYTE1: byte_q <= payload_byte1(wr_d);
            default: byte_q <= 8'h00;
         endcase
         if (idx_inc)  idx_q       <= idx_q + 4'd1;
         if (init_fin) init_done_q <= 1'b1;
         if (err_set)  err_q       <= 1'b1;
      end
   end

   // Current register write, held stable for the whole transaction.
   always_ff @(posedge clk) begin
      wr_q <= wr_d;
   end

   assign req_ready       = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign state_info      = state_q;
   assign i2c_enable      = en_q;
   assign i2c_input_byte  = byte_q;
   assign i2c_mode        = 1'b1;
   assign i2c_periph_addr = PERIPH_ADDR;
   assign init_done       = init_done_q;
   assign error           = err_q;

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Self-checking bench for codec_cfg_scheduler with a behavioural I2C byte
// controller model and a transaction-level scoreboard.
module tb_codec_cfg_scheduler;

   localparam int TO_I  = 60;
   localparam int GAP_I = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid;
   logic [6:0] req_reg;
   logic [8:0] req_data;
   logic       req_ready;
   logic       i2c_enable;
   logic       i2c_mode;
   logic [6:0] i2c_periph_addr;
   logic [7:0] i2c_input_byte;
   logic       i2c_ready;
   logic       i2c_wip;
   logic       init_done;
   logic       busy;
   logic       error;
   logic [3:0] state_info;

   always #5 clk = ~clk;

   codec_cfg_scheduler #(
      .PERIPH_ADDR    (7'b0011010),
      .INIT_LEN       (6),
      .TIMEOUT_CYCLES (20'(TO_I)),
      .GAP_CYCLES     (16'(GAP_I))
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .req_valid             (req_valid),
      .req_reg               (req_reg),
      .req_data              (req_data),
      .req_ready             (req_ready),
      .i2c_enable            (i2c_enable),
      .i2c_mode              (i2c_mode),
      .i2c_periph_addr       (i2c_periph_addr),
      .i2c_input_byte        (i2c_input_byte),
      .i2c_ready             (i2c_ready),
      .i2c_write_in_progress (i2c_wip),
      .init_done             (init_done),
      .busy                  (busy),
      .error                 (error),
      .state_info            (state_info)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- I2C byte controller model ----------------
   // Transaction record: {byte count, first byte, second byte}.
   logic [23:0] obs_q[$];
   logic [23:0] exp_q[$];
   int          c_phase, c_cnt, c_nb, c_txn;
   logic [7:0]  c_b0, c_b1;
   bit          rnd = 1'b0;
   int          skip_txn = -1;
   int          hold_txn = -1;
   int          n_acc = 0;

   function automatic int dly();
      return rnd ? int'($urandom_range(1, 5)) : 3;
   endfunction

   function automatic int shl();
      return rnd ? int'($urandom_range(1, 6)) : 4;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         c_phase   = 0;
         c_nb      = 0;
         c_txn     = 0;
         i2c_ready = 1'b1;
         i2c_wip   = 1'b0;
      end else begin
         case (c_phase)
            0: if (i2c_enable) begin
               i2c_ready = 1'b0;
               c_nb = 0; c_b0 = 8'h00; c_b1 = 8'h00;
               c_phase = 1; c_cnt = dly();
            end
            1: begin
               if (!i2c_enable) begin
                  c_phase = 3; c_cnt = 2;
               end else if (c_cnt > 1) begin
                  c_cnt--;
               end else if (c_txn != skip_txn) begin
                  i2c_wip = 1'b1;
                  if (c_nb == 0) c_b0 = i2c_input_byte;
                  else           c_b1 = i2c_input_byte;
                  c_nb++;
                  c_phase = 2; c_cnt = shl();
               end
            end
            2: begin
               if (c_txn == hold_txn) begin
                  if (!i2c_enable) begin
                     i2c_wip = 1'b0; c_phase = 3; c_cnt = 2;
                  end
               end else if (c_cnt > 1) begin
                  c_cnt--;
               end else begin
                  i2c_wip = 1'b0; c_phase = 1; c_cnt = dly();
               end
            end
            default: begin
               if (c_cnt > 1) begin
                  c_cnt--;
               end else begin
                  i2c_ready = 1'b1;
                  obs_q.push_back({8'(c_nb), c_b0, c_b1});
                  c_txn++;
                  c_phase = 0;
               end
            end
         endcase
      end
   end

   always @(posedge clk) begin
      if (reset_n && req_valid && req_ready) n_acc++;
   end

   // ---------------- reference helpers ----------------
   function automatic logic [15:0] spec_init(input int i);
      case (i)
         0:       return {7'h0F, 9'h000};
         1:       return {7'h06, 9'h000};
         2:       return {7'h04, 9'h012};
         3:       return {7'h07, 9'h002};
         4:       return {7'h08, 9'h000};
         default: return {7'h09, 9'h001};
      endcase
   endfunction

   function automatic logic [23:0] txn_exp(input logic [6:0] r, input logic [8:0] d, input int nb);
      logic [7:0] b0, b1;
      b0 = (nb > 0) ? {r, d[8]} : 8'h00;
      b1 = (nb > 1) ? d[7:0] : 8'h00;
      return {8'(nb), b0, b1};
   endfunction

   task automatic push_init(input int skip);
      logic [15:0] e;
      for (int i = 0; i < 6; i++) begin
         e = spec_init(i);
         exp_q.push_back(txn_exp(e[15:9], e[8:0], (i == skip) ? 0 : 2));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic score(input string tag);
      logic [23:0] e, o;
      chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk(tag, 32'(o), 32'(e));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic wait_idle(input string tag, input int nexp);
      bit done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         tick();
         if (!busy && obs_q.size() >= nexp) done = 1'b1;
      end
      chk({tag, "_idle_bound"}, 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      obs_q.delete();
      exp_q.delete();
      n_acc = 0;
      reset_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [6:0]  r;
      logic [8:0]  d;
      logic [23:0] o;
      bit          done, seen, ok, stay;
      int          early, gap_cyc, st3;

      reset_n = 1'b0; req_valid = 1'b0; req_reg = 7'h00; req_data = 9'h000;
      repeat (2) tick();
      chk("rst_enable",    32'(i2c_enable),      32'd0);
      chk("rst_byte",      32'(i2c_input_byte),  32'd0);
      chk("rst_req_ready", 32'(req_ready),       32'd0);
      chk("rst_init_done", 32'(init_done),       32'd0);
      chk("rst_busy",      32'(busy),            32'd1);
      chk("rst_error",     32'(error),           32'd0);
      chk("rst_state",     32'(state_info),      32'd0);
      chk("rst_mode",      32'(i2c_mode),        32'd1);
      chk("rst_periph",    32'(i2c_periph_addr), 32'h1A);

      // Request held high from reset onwards: must wait for init_done.
      req_valid = 1'b1; req_reg = 7'h02; req_data = 9'h17F;
      tick();
      reset_n = 1'b1;
      done = 1'b0; early = 0; gap_cyc = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         tick();
         if (init_done) done = 1'b1;
         else begin
            if (req_ready) early++;
            if (state_info == 4'd6) gap_cyc++;
         end
      end
      chk("init_bound",   32'(done),  32'd1);
      chk("early_ready",  32'(early), 32'd0);
      chk("gap_len", 32'(gap_cyc),
          32'((gap_cyc == 6 * (GAP_I + 1)) ? 6 * (GAP_I + 1) : 6 * GAP_I));
      chk("init_error",   32'(error),     32'd0);
      chk("idle_ready",   32'(req_ready), 32'd1);
      chk("idle_busy",    32'(busy),      32'd0);
      tick();
      chk("req_lat_en",   32'(i2c_enable),     32'd1);
      chk("req_lat_b0",   32'(i2c_input_byte), 32'h05);
      chk("req_ready_lo", 32'(req_ready),      32'd0);
      req_valid = 1'b0;
      push_init(-1);
      exp_q.push_back(txn_exp(7'h02, 9'h17F, 2));
      wait_idle("init", 7);
      chk("accept_once", 32'(n_acc), 32'd1);
      score("init_seq");

      // Randomised runtime requests with random controller timing.
      rnd = 1'b1;
      for (int k = 0; k < 10; k++) begin
         ok = 1'b0;
         for (int j = 0; j < 3000 && !ok; j++) begin
            if (req_ready) ok = 1'b1;
            else tick();
         end
         chk("rnd_ready_bound", 32'(ok), 32'd1);
         repeat ($urandom_range(0, 3)) tick();
         r = 7'($urandom);
         d = 9'($urandom);
         req_reg = r; req_data = d; req_valid = 1'b1;
         tick();
         chk("rnd_lat_en", 32'(i2c_enable),     32'd1);
         chk("rnd_lat_b0", 32'(i2c_input_byte), 32'({r, d[8]}));
         req_valid = 1'b0;
         exp_q.push_back(txn_exp(r, d, 2));
      end
      wait_idle("rnd", 10);
      score("rnd_seq");
      chk("rnd_error", 32'(error), 32'd0);

      // Third init entry never gets a wip: timeout, skip, continue.
      rnd = 1'b0;
      skip_txn = 2;
      do_reset();
      done = 1'b0; seen = 1'b0; st3 = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         tick();
         if (init_done) done = 1'b1;
         if (state_info == 4'd3 && c_txn == 2) st3++;
         if (error && !seen) begin
            seen = 1'b1;
            chk("to_enable", 32'(i2c_enable), 32'd0);
            chk("to_state",  32'(state_info), 32'd5);
         end
      end
      chk("to_bound",     32'(done),  32'd1);
      chk("to_seen",      32'(seen),  32'd1);
      chk("to_error",     32'(error), 32'd1);
      chk("to_len", 32'(st3), 32'((st3 == TO_I + 1) ? TO_I + 1 : TO_I));
      push_init(2);
      wait_idle("to", 6);
      score("to_seq");
      skip_txn = -1;

      // wip held high across both bytes: exactly one advance.
      hold_txn = 0;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick();
         if (state_info == 4'd4) ok = 1'b1;
      end
      chk("hold_reach", 32'(ok), 32'd1);
      stay = 1'b1;
      repeat (20) begin
         tick();
         if (state_info != 4'd4) stay = 1'b0;
      end
      chk("hold_stay",  32'(stay),  32'd1);
      chk("hold_noerr", 32'(error), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (error) ok = 1'b1;
      end
      chk("hold_err",   32'(ok),         32'd1);
      chk("hold_en",    32'(i2c_enable), 32'd0);
      chk("hold_state", 32'(state_info), 32'd5);
      hold_txn = -1;

      // Reset asserted mid-transaction in S_BYTE1.
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick();
         if (state_info == 4'd4) ok = 1'b1;
      end
      chk("mid_reach", 32'(ok), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_en",    32'(i2c_enable), 32'd0);
      chk("mid_state", 32'(state_info), 32'd0);
      repeat (3) tick();
      obs_q.delete();
      reset_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         tick();
         if (obs_q.size() > 0) ok = 1'b1;
      end
      chk("mid_bound", 32'(ok), 32'd1);
      o = (obs_q.size() > 0) ? obs_q[0] : 24'h0;
      chk("mid_b0", 32'(o[15:8]), 32'h1E);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
